// File: rtl/i2s_src_sched_if.sv
// Sample bus between the audio producers/serializer and the I2S source scheduler.
// The master side drives producer samples, mode and the load strobe; the slave is the scheduler.
interface i2s_src_sched_if;
    logic [1:0]  mode;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic        load;
    logic [15:0] l_data;
    logic [15:0] r_data;
    logic [1:0]  active;
    logic [7:0]  urun_cnt;
    logic        urun_clr;

    modport master (
        output mode, a_data, a_valid, b_data, b_valid, load, urun_clr,
        input  a_ready, b_ready, l_data, r_data, active, urun_cnt
    );

    modport slave (
        input  mode, a_data, a_valid, b_data, b_valid, load, urun_clr,
        output a_ready, b_ready, l_data, r_data, active, urun_cnt
    );
endinterface

// File: rtl/i2s_src_sched.sv
// Two-source stereo sample scheduler feeding the I2S serializer: per-source FIFOs,
// start-up priming, underrun handling and mode/source selection on the load strobe.
module i2s_src_sched #(
    parameter int DEPTH        = 4,
    parameter int PRIME        = 2,
    parameter int HOLD_ON_URUN = 0
) (
    input  logic               clk,
    input  logic               reset,
    i2s_src_sched_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {ST_MUTE = 2'd0, ST_PRIME = 2'd1, ST_RUN = 2'd2} state_t;

    state_t          state_r, state_nxt_s;
    logic [31:0]     a_mem_r [DEPTH];
    logic [31:0]     b_mem_r [DEPTH];
    logic [AW-1:0]   a_wr_r, a_rd_r, b_wr_r, b_rd_r;
    logic [LW-1:0]   a_level_r, b_level_r, elig_level_s;
    logic            a_ready_s, b_ready_s, push_a_s, push_b_s, pop_a_s, pop_b_s;
    logic [1:0]      mode_prev_r;
    logic            mode_chg_s, elig_b_s, prime_ok_s, urun_inc_s;
    logic [15:0]     l_data_r, r_data_r, nxt_l_s, nxt_r_s;
    logic [1:0]      active_r, nxt_active_s;
    logic [7:0]      urun_cnt_r;
    logic [31:0]     a_head_s, b_head_s;

    // Ready is withheld during reset; a full FIFO refuses pushes even when popped that cycle.
    assign a_ready_s = !reset && (a_level_r != LW'(DEPTH));
    assign b_ready_s = !reset && (b_level_r != LW'(DEPTH));
    assign push_a_s  = bus.a_valid && a_ready_s;
    assign push_b_s  = bus.b_valid && b_ready_s;
    assign a_head_s  = a_mem_r[a_rd_r];
    assign b_head_s  = b_mem_r[b_rd_r];

    assign mode_chg_s   = (bus.mode != mode_prev_r);
    assign elig_b_s     = (bus.mode == 2'd1) || ((bus.mode == 2'd2) && (b_level_r != LW'(0)));
    assign elig_level_s = elig_b_s ? b_level_r : a_level_r;
    assign prime_ok_s   = (bus.mode == 2'd2) ?
                          ((a_level_r >= LW'(PRIME)) || (b_level_r >= LW'(PRIME))) :
                          (elig_level_s >= LW'(PRIME));

    // Sample storage; stale contents are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (push_a_s) a_mem_r[a_wr_r] <= bus.a_data;
        if (push_b_s) b_mem_r[b_wr_r] <= bus.b_data;
    end

    // FIFO pointers and fill levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_wr_r <= AW'(0); a_rd_r <= AW'(0); a_level_r <= LW'(0);
            b_wr_r <= AW'(0); b_rd_r <= AW'(0); b_level_r <= LW'(0);
        end else begin
            if (push_a_s) a_wr_r <= a_wr_r + AW'(1);
            if (pop_a_s)  a_rd_r <= a_rd_r + AW'(1);
            if (push_b_s) b_wr_r <= b_wr_r + AW'(1);
            if (pop_b_s)  b_rd_r <= b_rd_r + AW'(1);
            a_level_r <= a_level_r + LW'(push_a_s) - LW'(pop_a_s);
            b_level_r <= b_level_r + LW'(push_b_s) - LW'(pop_b_s);
        end
    end

    // State register and the mode seen at the previous load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_MUTE;
            mode_prev_r <= 2'd3;
        end else if (bus.load) begin
            state_r     <= state_nxt_s;
            mode_prev_r <= bus.mode;
        end
    end

    // Next-state decision, only meaningful on load cycles.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_MUTE:  state_nxt_s = (bus.mode != 2'd3) ? ST_PRIME : ST_MUTE;
            ST_PRIME: begin
                if (bus.mode == 2'd3)      state_nxt_s = ST_MUTE;
                else if (mode_chg_s)       state_nxt_s = ST_PRIME;
                else if (prime_ok_s)       state_nxt_s = ST_RUN;
                else                       state_nxt_s = ST_PRIME;
            end
            ST_RUN: begin
                if (bus.mode == 2'd3)              state_nxt_s = ST_MUTE;
                else if (mode_chg_s)               state_nxt_s = ST_PRIME;
                else if (elig_level_s == LW'(0))   state_nxt_s = ST_PRIME;
                else                               state_nxt_s = ST_RUN;
            end
            default:  state_nxt_s = ST_MUTE;
        endcase
    end

    // Output/pop decision: only a steady-mode RUN load moves samples.
    always_comb begin
        nxt_l_s      = 16'd0;
        nxt_r_s      = 16'd0;
        nxt_active_s = 2'd0;
        pop_a_s      = 1'b0;
        pop_b_s      = 1'b0;
        urun_inc_s   = 1'b0;
        if (bus.load && (state_r == ST_RUN) && !mode_chg_s && (bus.mode != 2'd3)) begin
            if (elig_level_s != LW'(0)) begin
                if (elig_b_s) begin
                    pop_b_s      = 1'b1;
                    nxt_l_s      = b_head_s[31:16];
                    nxt_r_s      = b_head_s[15:0];
                    nxt_active_s = 2'd2;
                end else begin
                    pop_a_s      = 1'b1;
                    nxt_l_s      = a_head_s[31:16];
                    nxt_r_s      = a_head_s[15:0];
                    nxt_active_s = 2'd1;
                end
            end else begin
                urun_inc_s = 1'b1;
                if (HOLD_ON_URUN != 0) begin
                    nxt_l_s      = l_data_r;
                    nxt_r_s      = r_data_r;
                    nxt_active_s = 2'd3;
                end else begin
                    nxt_active_s = 2'd0;
                end
            end
        end else begin
            urun_inc_s = 1'b0;
        end
    end

    // Registered serializer outputs, frozen between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_data_r <= 16'd0;
            r_data_r <= 16'd0;
            active_r <= 2'd0;
        end else if (bus.load) begin
            l_data_r <= nxt_l_s;
            r_data_r <= nxt_r_s;
            active_r <= nxt_active_s;
        end
    end

    // Saturating underrun counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset)                                    urun_cnt_r <= 8'd0;
        else if (bus.urun_clr)                        urun_cnt_r <= 8'd0;
        else if (urun_inc_s && (urun_cnt_r != 8'hFF)) urun_cnt_r <= urun_cnt_r + 8'd1;
    end

    assign bus.a_ready  = a_ready_s;
    assign bus.b_ready  = b_ready_s;
    assign bus.l_data   = l_data_r;
    assign bus.r_data   = r_data_r;
    assign bus.active   = active_r;
    assign bus.urun_cnt = urun_cnt_r;
endmodule
